// File: rtl/lab4d_shift_register_multi.sv
// LAB4D serial register loader for NUM_LAB chips.
// Shifts a DATA_WIDTH word MSB-first on SIN/SCLK to one chip (or all chips in
// broadcast), then latches it with a PCLK strobe followed by a hold phase.
// Each phase lasts prescale+1 clocks; all pins come straight from flops.
// Optional build macro: LAB4D_SR_READBACK_EN adds SOUT/rdat_o readback.
module lab4d_shift_register_multi #(
  parameter int NUM_LAB    = 12,
  parameter int DATA_WIDTH = 24,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  go_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic                  bcast_i,
  input  logic [7:0]            prescale_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [NUM_LAB-1:0]    SIN,
  output logic [NUM_LAB-1:0]    SCLK,
  output logic [NUM_LAB-1:0]    PCLK
`ifdef LAB4D_SR_READBACK_EN
  ,
  input  logic [NUM_LAB-1:0]    SOUT,
  output logic [DATA_WIDTH-1:0] rdat_o
`endif
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [SEL_WIDTH:0] NUM_LAB_W = (SEL_WIDTH+1)'(NUM_LAB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_PCLK,
    S_HOLD
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_next;
  logic [7:0]            r_presc;
  logic [BIT_W-1:0]      r_bit;
  logic [BIT_W-1:0]      w_bit_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [SEL_WIDTH-1:0]  w_sel_next;
  logic                  r_bcast;
  logic                  w_bcast_next;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [NUM_LAB-1:0]    r_sin;
  logic [NUM_LAB-1:0]    r_sclk;
  logic [NUM_LAB-1:0]    r_pclk;

  logic                  w_req;
  logic                  w_sel_ok;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_phase_end;
  logic                  w_done_next;
  logic                  w_sin_bit;
  logic                  w_sclk_bit;
  logic                  w_pclk_bit;
  logic [NUM_LAB-1:0]    w_mask_next;
  logic [NUM_LAB-1:0]    w_sin_next;
  logic [NUM_LAB-1:0]    w_sclk_next;
  logic [NUM_LAB-1:0]    w_pclk_next;

  // A request is only looked at in IDLE and never during the done cycle,
  // so a go_i held high cannot retrigger before the strobe has been seen.
  assign w_req       = (r_state == S_IDLE) && go_i && !r_done;
  assign w_sel_ok    = bcast_i || ({1'b0, sel_i} < NUM_LAB_W);
  assign w_accept    = w_req && w_sel_ok;
  assign w_reject    = w_req && !w_sel_ok;
  assign w_phase_end = (r_cnt == 8'd0);

  // Next-state, phase counter, bit counter and shift register
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_SETUP;
          w_cnt_next   = prescale_i;
          w_bit_next   = BIT_W'(DATA_WIDTH-1);
          w_shift_next = dat_i;
        end
      end
      S_SETUP: begin
        if (w_phase_end) begin
          w_state_next = S_HIGH;
          w_cnt_next   = r_presc;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      S_HIGH: begin
        if (w_phase_end) begin
          w_cnt_next   = r_presc;
          w_shift_next = {r_shift[DATA_WIDTH-2:0], 1'b0};
          if (r_bit == '0) begin
            w_state_next = S_PCLK;
          end else begin
            w_state_next = S_SETUP;
            w_bit_next   = r_bit - BIT_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      S_PCLK: begin
        if (w_phase_end) begin
          w_state_next = S_HOLD;
          w_cnt_next   = r_presc;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      S_HOLD: begin
        if (w_phase_end) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Target selection as it will be after this edge (new request or held)
  assign w_sel_next   = w_accept ? sel_i   : r_sel;
  assign w_bcast_next = w_accept ? bcast_i : r_bcast;

  // Pin levels implied by the next state; gated per channel below
  assign w_sin_bit  = ((w_state_next == S_SETUP) || (w_state_next == S_HIGH))
                      && w_shift_next[DATA_WIDTH-1];
  assign w_sclk_bit = (w_state_next == S_HIGH);
  assign w_pclk_bit = (w_state_next == S_PCLK);

  for (genvar gi = 0; gi < NUM_LAB; gi++) begin : g_ch
    assign w_mask_next[gi] = w_bcast_next || (w_sel_next == SEL_WIDTH'(gi));
    assign w_sin_next[gi]  = w_mask_next[gi] && w_sin_bit;
    assign w_sclk_next[gi] = w_mask_next[gi] && w_sclk_bit;
    assign w_pclk_next[gi] = w_mask_next[gi] && w_pclk_bit;
  end

  // State, counters and captured request fields
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_presc <= 8'd0;
      r_bit   <= '0;
      r_shift <= '0;
      r_sel   <= '0;
      r_bcast <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_sel   <= w_sel_next;
      r_bcast <= w_bcast_next;
      if (w_accept) begin
        r_presc <= prescale_i;
      end
    end
  end

  // Registered status flags and pin drivers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_sin  <= '0;
      r_sclk <= '0;
      r_pclk <= '0;
    end else begin
      r_busy <= (w_state_next != S_IDLE);
      r_done <= w_done_next;
      r_err  <= w_reject;
      r_sin  <= w_sin_next;
      r_sclk <= w_sclk_next;
      r_pclk <= w_pclk_next;
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign err_o  = r_err;
  assign SIN    = r_sin;
  assign SCLK   = r_sclk;
  assign PCLK   = r_pclk;

`ifdef LAB4D_SR_READBACK_EN
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_rdat;
  logic [NUM_LAB-1:0]    w_mask_cur;
  logic                  w_sout_bit;

  for (genvar gi = 0; gi < NUM_LAB; gi++) begin : g_rb
    assign w_mask_cur[gi] = (r_sel == SEL_WIDTH'(gi));
  end

  // Broadcast reads chip 0; otherwise the addressed chip
  assign w_sout_bit = r_bcast ? SOUT[0] : |(SOUT & w_mask_cur);

  // Sample SOUT at the end of every HIGH phase; publish with done_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx   <= '0;
      r_rdat <= '0;
    end else begin
      if (w_accept) begin
        r_rx <= '0;
      end else if ((r_state == S_HIGH) && w_phase_end) begin
        r_rx <= {r_rx[DATA_WIDTH-2:0], w_sout_bit};
      end
      if (w_done_next) begin
        r_rdat <= r_rx;
      end
    end
  end

  assign rdat_o = r_rdat;
`endif

endmodule
